// File: rtl/display_sender.sv
// Transmit side of the four-slot display path: FIFO-buffers nonzero bytes and frames them onto inp/priem/SET.
// Optional build macro DISPLAY_SENDER_RR_EN selects round-robin slot choice instead of lowest free slot.
module display_sender #(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned GAP   = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic [3:0] slot_full,
  output logic [7:0] inp,
  output logic       priem,
  output logic [3:0] SET,
  output logic       busy,
  output logic       drop_zero
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DRIVE   = 2'd1;
  localparam logic [1:0] S_HOLDOFF = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic          start;
  logic [1:0]    base;
  logic [1:0]    pick_idx;
  logic          found;
  logic [3:0]    pick;

  assign push  = wr_en & wr_ready & (wr_data != 8'h00);
  assign pop   = (state == S_DRIVE) && (cnt == 4'd1);
  assign start = (state == S_IDLE) && (count != '0) && (slot_full != 4'b1111);
  assign busy  = (state != S_IDLE);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  // wr_ready tracks the post-edge count, so a write seen while it is low is dropped even if a pop coincides
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      wr_ready  <= 1'b1;
      drop_zero <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      wr_ready  <= (count_next != CW'(DEPTH));
      drop_zero <= wr_en & (wr_data == 8'h00);
    end
  end

`ifdef DISPLAY_SENDER_RR_EN
  logic [1:0] rot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rot <= '0;
    else if (start)
      rot <= pick_idx + 2'd1;
  end

  assign base = rot;
`else
  assign base = 2'd0;
`endif

  // Search the four slots starting at base, wrapping, first free slot wins
  always_comb begin
    pick_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!found && !slot_full[base + 2'(i)]) begin
        pick_idx = base + 2'(i);
        found    = 1'b1;
      end
    end
  end

  assign pick = 4'b0001 << pick_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      inp   <= '0;
      priem <= 1'b0;
      SET   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            inp   <= mem[rd_ptr];
            SET   <= pick;
            priem <= 1'b1;
            cnt   <= 4'(HOLD);
            state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (cnt == 4'd1) begin
            priem <= 1'b0;
            cnt   <= 4'(GAP);
            state <= S_HOLDOFF;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_HOLDOFF: begin
          if (cnt == 4'd1) begin
            inp   <= '0;
            SET   <= '0;
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          inp   <= '0;
          SET   <= '0;
          priem <= 1'b0;
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_sender.sv
// Scoreboard bench for display_sender: a timeline model predicts frames, a negedge monitor checks bus shape.
`timescale 1ns/1ps
module tb_display_sender;

  localparam int unsigned HOLD  = 4;
  localparam int unsigned GAP   = 2;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [3:0] slot_full;
  logic [7:0] inp;
  logic       priem;
  logic [3:0] SET;
  logic       busy;
  logic       drop_zero;

  always #5 clk = ~clk;

  display_sender #(.HOLD(HOLD), .GAP(GAP), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .slot_full(slot_full), .inp(inp), .priem(priem), .SET(SET), .busy(busy),
    .drop_zero(drop_zero)
  );

  typedef struct {
    logic [7:0]  data;
    logic [3:0]  set;
    int unsigned t;
  } frame_t;

  frame_t      sb[$];
  logic [7:0]  pend[$];
  int unsigned timer = 0;
  int unsigned cyc = 0;
  int unsigned rot = 0;
  logic        exp_ready = 1'b1;
  logic        exp_dz = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int pick_slot(input logic [3:0] full, input int unsigned from);
    for (int k = 0; k < 4; k++) begin
      int unsigned s;
      s = (from + k) % 4;
      if (!full[s]) return s;
    end
    return -1;
  endfunction

  // Reference model: FIFO as a queue, frame as a countdown of HOLD+GAP cycles with pop after HOLD
  frame_t      nf;
  int          slot;
  int unsigned pre;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
      sb.delete();
      timer     = 0;
      rot       = 0;
      exp_ready = 1'b1;
      exp_dz    = 1'b0;
    end else begin
      cyc++;
      pre = pend.size();
      if (timer == 0) begin
        if (pre != 0 && slot_full != 4'hF) begin
`ifdef DISPLAY_SENDER_RR_EN
          slot = pick_slot(slot_full, rot);
`else
          slot = pick_slot(slot_full, 0);
`endif
          nf.data = pend[0];
          nf.set  = 4'b0001 << slot;
          nf.t    = cyc;
          sb.push_back(nf);
          rot   = (slot + 1) % 4;
          timer = HOLD + GAP;
        end
      end else begin
        timer--;
        if (timer == GAP) void'(pend.pop_front());
      end
      if (wr_en && wr_data != 8'h00 && pre != DEPTH) pend.push_back(wr_data);
      exp_dz    = wr_en && (wr_data == 8'h00);
      exp_ready = (pend.size() != DEPTH);
    end
  end

  logic        mon_active = 1'b0;
  int unsigned ph = 0;
  frame_t      cur;
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      chk("wr_ready", wr_ready, exp_ready);
      chk("drop_zero", drop_zero, exp_dz);
      if (mon_active) begin
        ph++;
        if (ph < HOLD) begin
          chk("priem_high", priem, 1);
          chk("inp_drive", inp, cur.data);
          chk("set_drive", SET, cur.set);
          chk("busy_drive", busy, 1);
        end else if (ph < HOLD + GAP) begin
          chk("priem_gap", priem, 0);
          chk("inp_gap", inp, cur.data);
          chk("set_gap", SET, cur.set);
          chk("busy_gap", busy, 1);
        end else begin
          chk("priem_after", priem, 0);
          chk("inp_after", inp, 0);
          chk("set_after", SET, 0);
          chk("busy_after", busy, 0);
          mon_active = 1'b0;
        end
      end else if (priem) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame at %0t: got inp=%0h SET=%b expected no frame", $time, inp, SET);
          cur.data = inp;
          cur.set  = SET;
        end else begin
          cur = sb.pop_front();
          chk("frame_data", inp, cur.data);
          chk("frame_set", SET, cur.set);
          chk("frame_time", cyc, cur.t);
        end
        chk("busy_start", busy, 1);
        mon_active = 1'b1;
        ph = 0;
      end else begin
        chk("idle_inp", inp, 0);
        chk("idle_set", SET, 0);
        chk("idle_busy", busy, 0);
      end
    end
  end

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    wr_data = 8'h00;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((pend.size() != 0 || timer != 0 || sb.size() != 0 || mon_active) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", (n < 300), 1);
    idle(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog at %0t: got no finish expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; slot_full = 4'h0;
    idle(3);
    chk("rst_inp", inp, 0);
    chk("rst_priem", priem, 0);
    chk("rst_set", SET, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop_zero", drop_zero, 0);
    chk("rst_wr_ready", wr_ready, 1);
    rst = 1'b0;
    idle(2);

    wr(8'h35);
    drain();

    wr(8'h00);
    idle(10);
    drain();

    slot_full = 4'hF;
    for (int i = 0; i < 5; i++) wr(8'h11 + 8'(i));
    idle(10);
    slot_full = 4'h0;
    drain();

    slot_full = 4'b0011;
    wr(8'h42);
    drain();
    slot_full = 4'h0;

    wr(8'h51); wr(8'h52); wr(8'h53);
    drain();

    wr(8'hA1); wr(8'hA2); wr(8'hA3);
    chk("pre_reset_priem", priem, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_priem", priem, 0);
    chk("mid_rst_inp", inp, 0);
    chk("mid_rst_set", SET, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_ready", wr_ready, 1);
    idle(2);
    rst = 1'b0;
    idle(30);

    for (int n = 0; n < 400; n++) begin
      wr_en = ($urandom_range(0, 2) == 0);
      wr_data = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      r = $urandom_range(0, 7);
      slot_full = (r < 3) ? 4'h0 : ((r == 7) ? 4'hF : 4'($urandom_range(0, 15)));
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    wr_data = 8'h00;
    slot_full = 4'h0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
